// File: rtl/trng_rr_scheduler_pkg.sv
// Shared types and sizing helpers for the TRNG round-robin scheduler.
package trng_rr_scheduler_pkg;

    localparam int unsigned DW_DEF    = 256;
    localparam int unsigned N_REQ_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Width of an index or counter covering n values; never narrower than 1 bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trng_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or above the pointer,
// otherwise lowest requester overall (wrap-around).
module rr_arbiter
    import trng_rr_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    localparam int unsigned IW   = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic             valid_o,
    output logic [N_REQ-1:0] grant_o,
    output logic [IW-1:0]    idx_o
);

    logic [IW-1:0] idx_hi;
    logic [IW-1:0] idx_lo;
    logic          found_hi;

    // Descending scan so the final assignment holds the lowest matching index.
    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_lo = IW'(i);
                if (IW'(i) >= ptr_i) begin
                    idx_hi   = IW'(i);
                    found_hi = 1'b1;
                end
            end
        end
    end

    assign valid_o = |req_i;
    assign idx_o   = found_hi ? idx_hi : idx_lo;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
        assign grant_o[gi] = valid_o && (idx_o == IW'(gi));
    end

endmodule

// File: rtl/trng_rr_scheduler.sv
// Shares one TRNG among N_REQ requesters: round-robin grant, run strobe,
// single-word capture and one-hot valid/ready hand-off to the winner.
module trng_rr_scheduler
    import trng_rr_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] rsp_vld_o,
    input  logic [N_REQ-1:0] rsp_rdy_i,
    output logic [DW-1:0]    rsp_data_o,
    output logic             trng_run_o,
    input  logic             trng_dvld_i,
    input  logic [DW-1:0]    trng_dout_i,
    output logic             busy_o,
    output logic             err_timeout_o
);

    localparam int unsigned IW = idx_w(N_REQ);
    localparam int unsigned CW = idx_w(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

    // Reset asserts asynchronously and releases two edges later on clk_i.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    state_e        state_q,  state_d;
    logic [IW-1:0] winner_q, winner_d;
    logic [IW-1:0] ptr_q,    ptr_d;
    logic [DW-1:0] data_q,   data_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          err_q,    err_d;

    logic             arb_valid;
    logic [N_REQ-1:0] arb_grant;
    logic [IW-1:0]    arb_idx;
    logic [IW-1:0]    ptr_next;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (arb_valid),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    assign ptr_next = (winner_q == IDX_LAST) ? '0 : winner_q + IW'(1);

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        ptr_d    = ptr_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    winner_d = arb_idx;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (trng_dvld_i) begin
                    data_d  = trng_dout_i;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    // Abandon the grant; the requester gets no word this round.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (rsp_rdy_i[winner_q]) begin
                    data_d  = '0;
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            winner_q <= '0;
            ptr_q    <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            ptr_q    <= ptr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_vld
        assign rsp_vld_o[gi] = (state_q == ST_HOLD) && (winner_q == IW'(gi));
    end

    assign rsp_data_o    = (state_q == ST_HOLD) ? data_q : '0;
    assign trng_run_o    = (state_q == ST_RUN);
    assign busy_o        = (state_q != ST_IDLE);
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_trng_rr_scheduler.sv
// Scenario bench for trng_rr_scheduler: RR model plus scoreboard of captured words.
module tb_trng_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic [N-1:0]  req_i;
    logic [N-1:0]  rsp_vld_o;
    logic [N-1:0]  rsp_rdy_i;
    logic [DW-1:0] rsp_data_o;
    logic          trng_run_o;
    logic          trng_dvld_i;
    logic [DW-1:0] trng_dout_i;
    logic          busy_o;
    logic          err_timeout_o;

    always #5 clk = ~clk;

    trng_rr_scheduler #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .req_i         (req_i),
        .rsp_vld_o     (rsp_vld_o),
        .rsp_rdy_i     (rsp_rdy_i),
        .rsp_data_o    (rsp_data_o),
        .trng_run_o    (trng_run_o),
        .trng_dvld_i   (trng_dvld_i),
        .trng_dout_i   (trng_dout_i),
        .busy_o        (busy_o),
        .err_timeout_o (err_timeout_o)
    );

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_ptr = 0;

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        int c;
        r = -1;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r = i;
                c++;
            end
        end
        return (c == 1) ? r : -1;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Drives one full grant/RUN/HOLD/handshake sequence; entered and left on a negedge.
    task automatic run_txn(input logic [N-1:0] req, input int run_wait, input logic [DW-1:0] word,
                           input logic drop_req, output int run_lat, output int got_idx,
                           output logic [DW-1:0] got_data, output logic [N-1:0] vld_after,
                           output logic [DW-1:0] data_after, output logic busy_after);
        int   n;
        exp_t e;
        req_i     = req;
        rsp_rdy_i = '1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!trng_run_o && n < 20);
        run_lat = n;
        repeat (run_wait - 1) @(negedge clk);
        e.idx  = rr_pick(req, m_ptr);
        e.data = word;
        sb_q.push_back(e);
        if (e.idx >= 0) m_ptr = (e.idx + 1) % N;
        trng_dvld_i = 1'b1;
        trng_dout_i = word;
        @(negedge clk);
        trng_dvld_i = 1'b0;
        trng_dout_i = rand_word();
        got_idx  = onehot_idx(rsp_vld_o);
        got_data = rsp_data_o;
        if (drop_req) req_i = '0;
        @(negedge clk);
        vld_after  = rsp_vld_o;
        data_after = rsp_data_o;
        busy_after = busy_o;
        rsp_rdy_i  = '0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({rsp_vld_o, trng_run_o, busy_o, err_timeout_o} !== 7'd0 || rsp_data_o !== '0) begin
            bad++;
            $display("FAIL reset_hold: vld=%b run=%b busy=%b err=%b data_nz=%b required all zero",
                     rsp_vld_o, trng_run_o, busy_o, err_timeout_o, |rsp_data_o);
        end
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({rsp_vld_o, trng_run_o, busy_o, err_timeout_o} !== 7'd0) begin
            bad++;
            $display("FAIL reset_release: vld=%b run=%b busy=%b err=%b required all zero",
                     rsp_vld_o, trng_run_o, busy_o, err_timeout_o);
        end
        $display("reset: done");
    endtask

    task automatic test_round_robin();
        int            lat, idx;
        logic [DW-1:0] d, da, prev;
        logic [N-1:0]  va;
        logic          ba;
        exp_t          e;
        prev = '0;
        for (int k = 0; k < 8; k++) begin
            run_txn(4'b1111, 2 + k % 3, rand_word(), (k == 7), lat, idx, d, va, da, ba);
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL rr_sb_empty: txn %0d has no expected entry", k);
                continue;
            end
            e = sb_q.pop_front();
            if (idx !== k % 4 || idx !== e.idx) begin
                bad++;
                $display("FAIL rr_order: txn %0d got winner %0d expected %0d", k, idx, k % 4);
            end
            total++;
            if (d !== e.data || d === prev) begin
                bad++;
                $display("FAIL rr_data: txn %0d got %h expected %h", k, d, e.data);
            end
            total++;
            if (lat !== 1 || ba !== 1'b0 || va !== '0) begin
                bad++;
                $display("FAIL rr_idle_gap: txn %0d run_lat=%0d busy_after=%b vld_after=%b expected 1,0,0",
                         k, lat, ba, va);
            end
            prev = d;
            $display("round_robin: txn %0d winner=%0d", k, idx);
        end
    endtask

    task automatic test_single();
        int            lat, idx;
        logic [DW-1:0] w, d, da;
        logic [N-1:0]  va;
        logic          ba;
        exp_t          e;
        w = {32{8'hA5}};
        run_txn(4'b0100, 5, w, 1'b1, lat, idx, d, va, da, ba);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL single_run_latency: got %0d cycles expected 1", lat);
        end
        total++;
        e = sb_q.pop_front();
        if (idx !== 2 || idx !== e.idx || d !== w) begin
            bad++;
            $display("FAIL single_rsp: winner %0d data %h expected 2 data %h", idx, d, w);
        end
        total++;
        if (va !== '0 || da !== '0) begin
            bad++;
            $display("FAIL single_after: vld=%b data=%h expected 0", va, da);
        end
        $display("single: winner=%0d", idx);
    endtask

    task automatic test_hold_stall();
        int            n;
        logic [DW-1:0] w;
        logic          stable;
        logic [N-1:0]  bad_vld;
        exp_t          e;
        w         = rand_word();
        req_i     = 4'b0010;
        rsp_rdy_i = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!trng_run_o && n < 20);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL stall_run_latency: got %0d expected 1", n);
        end
        repeat (2) @(negedge clk);
        e.idx  = rr_pick(4'b0010, m_ptr);
        e.data = w;
        sb_q.push_back(e);
        m_ptr = (e.idx + 1) % N;
        trng_dvld_i = 1'b1;
        trng_dout_i = w;
        @(negedge clk);
        stable    = 1'b1;
        bad_vld   = '0;
        rsp_rdy_i = 4'b1101;
        for (int c = 0; c < 20; c++) begin
            if (stable && (rsp_vld_o !== 4'b0010 || rsp_data_o !== w || trng_run_o !== 1'b0)) begin
                stable  = 1'b0;
                bad_vld = rsp_vld_o;
            end
            trng_dvld_i = c[0];
            trng_dout_i = rand_word();
            @(negedge clk);
        end
        trng_dvld_i = 1'b0;
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL stall_stable: vld=%b during stall expected 0010 with stable data and run=0", bad_vld);
        end
        total++;
        e = sb_q.pop_front();
        if (onehot_idx(rsp_vld_o) !== e.idx || rsp_data_o !== e.data) begin
            bad++;
            $display("FAIL stall_final: winner %0d data %h expected %0d data %h",
                     onehot_idx(rsp_vld_o), rsp_data_o, e.idx, e.data);
        end
        rsp_rdy_i = 4'b0010;
        req_i     = '0;
        @(negedge clk);
        rsp_rdy_i = '0;
        total++;
        if (rsp_vld_o !== '0 || rsp_data_o !== '0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_release: vld=%b busy=%b data=%h expected 0", rsp_vld_o, busy_o, rsp_data_o);
        end
        trng_dvld_i = 1'b1;
        trng_dout_i = rand_word();
        @(negedge clk);
        trng_dvld_i = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_vld_o !== '0 || trng_run_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_dvld_ignored: vld=%b run=%b busy=%b expected 0", rsp_vld_o, trng_run_o, busy_o);
        end
        $display("hold_stall: winner=%0d", e.idx);
    endtask

    task automatic test_timeout();
        int            n, n_run, win, lat, idx;
        logic          noresp;
        logic [DW-1:0] d, da;
        logic [N-1:0]  va;
        logic          ba;
        exp_t          e;
        req_i     = 4'b0001;
        rsp_rdy_i = '0;
        win       = rr_pick(4'b0001, m_ptr);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!trng_run_o && n < 20);
        req_i  = '0;
        n_run  = 1;
        noresp = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (|rsp_vld_o) noresp = 1'b0;
            if (!trng_run_o) break;
            n_run++;
        end
        m_ptr = (win + 1) % N;
        total++;
        if (n_run !== TO) begin
            bad++;
            $display("FAIL timeout_cycles: got %0d RUN cycles expected %0d", n_run, TO);
        end
        total++;
        if (err_timeout_o !== 1'b1 || busy_o !== 1'b0 || !noresp) begin
            bad++;
            $display("FAIL timeout_abort: err=%b busy=%b noresp=%b expected 1,0,1", err_timeout_o, busy_o, noresp);
        end
        run_txn(4'b0010, 4, rand_word(), 1'b1, lat, idx, d, va, da, ba);
        e = sb_q.pop_front();
        total++;
        if (idx !== 1 || idx !== e.idx || d !== e.data) begin
            bad++;
            $display("FAIL timeout_next: winner %0d data %h expected 1 data %h", idx, d, e.data);
        end
        total++;
        if (err_timeout_o !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: err=%b expected 1", err_timeout_o);
        end
        $display("timeout: run_cycles=%0d", n_run);
    endtask

    task automatic test_async_reset();
        int            n, lat, idx;
        logic [DW-1:0] d, da;
        logic [N-1:0]  va;
        logic          ba;
        exp_t          e;
        req_i     = 4'b0100;
        rsp_rdy_i = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!trng_run_o && n < 20);
        trng_dvld_i = 1'b1;
        trng_dout_i = rand_word();
        @(negedge clk);
        trng_dvld_i = 1'b0;
        total++;
        if (rsp_vld_o !== 4'b0100) begin
            bad++;
            $display("FAIL arst_pre_hold: vld=%b expected 0100", rsp_vld_o);
        end
        #2 rst_n_i = 1'b0;
        #1;
        total++;
        if (rsp_vld_o !== '0 || trng_run_o !== 1'b0 || busy_o !== 1'b0 || rsp_data_o !== '0
            || err_timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL arst_immediate: vld=%b run=%b busy=%b err=%b expected all 0",
                     rsp_vld_o, trng_run_o, busy_o, err_timeout_o);
        end
        sb_q.delete();
        m_ptr = 0;
        req_i = '0;
        @(negedge clk);
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk);
        run_txn(4'b1010, 3, rand_word(), 1'b1, lat, idx, d, va, da, ba);
        e = sb_q.pop_front();
        total++;
        if (idx !== 1 || idx !== e.idx || d !== e.data) begin
            bad++;
            $display("FAIL arst_ptr_restart: winner %0d expected 1", idx);
        end
        run_txn(4'b1000, 2, rand_word(), 1'b1, lat, idx, d, va, da, ba);
        e = sb_q.pop_front();
        total++;
        if (idx !== 3 || idx !== e.idx || d !== e.data) begin
            bad++;
            $display("FAIL arst_req3: winner %0d data %h expected 3 data %h", idx, d, e.data);
        end
        $display("async_reset: post-reset winners served");
    endtask

    task automatic test_wrap();
        int            lat, idx;
        logic [DW-1:0] d, da;
        logic [N-1:0]  va;
        logic          ba;
        exp_t          e;
        for (int k = 0; k < 3; k++) begin
            run_txn(4'b1000, 2, rand_word(), (k == 2), lat, idx, d, va, da, ba);
            e = sb_q.pop_front();
            total++;
            if (idx !== 3 || idx !== e.idx || d !== e.data) begin
                bad++;
                $display("FAIL wrap_winner: txn %0d winner %0d expected 3", k, idx);
            end
            total++;
            if (lat !== 1 || ba !== 1'b0 || va !== '0 || da !== '0) begin
                bad++;
                $display("FAIL wrap_gap: txn %0d run_lat=%0d busy_after=%b expected 1,0", k, lat, ba);
            end
            $display("wrap: txn %0d winner=%0d", k, idx);
        end
    endtask

    initial begin
        rst_n_i     = 1'b0;
        req_i       = '0;
        rsp_rdy_i   = '0;
        trng_dvld_i = 1'b0;
        trng_dout_i = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_hold_stall();
        test_timeout();
        test_async_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
